// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing signal bundle of the branch resolve queue.
// The slave modport is the queue; the master modport drives it.
interface branch_resolve_queue_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16,
    parameter int OCC_W = 3
);
    logic              push;
    logic [PC_W-1:0]   push_pc;
    logic              push_pred_taken;
    logic [PC_W-1:0]   push_pred_target;
    logic              resolve;
    logic              resolve_taken;
    logic [PC_W-1:0]   resolve_target;
    logic              full;
    logic              empty;
    logic [OCC_W-1:0]  occupancy;
    logic              update;
    logic [7:0]        update_address;
    logic              branch_taken;
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output push, push_pc, push_pred_taken, push_pred_target,
               resolve, resolve_taken, resolve_target,
        input  full, empty, occupancy, update, update_address, branch_taken,
               mispredict, redirect_pc, branch_count, mispredict_count,
               overflow_err, underflow_err
    );

    modport slave (
        input  push, push_pc, push_pred_taken, push_pred_target,
               resolve, resolve_taken, resolve_target,
        output full, empty, occupancy, update, update_address, branch_taken,
               mispredict, redirect_pc, branch_count, mispredict_count,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the head against execute,
// pulses the predictor update and a registered mispredict/redirect.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PC_W-1:0]  entry_pc_q     [DEPTH];
    logic [PC_W-1:0]  entry_pc_d     [DEPTH];
    logic [PC_W-1:0]  entry_target_q [DEPTH];
    logic [PC_W-1:0]  entry_target_d [DEPTH];
    logic [DEPTH-1:0] entry_taken_q, entry_taken_d;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             update_q, update_d;
    logic [7:0]       update_address_q, update_address_d;
    logic             branch_taken_q, branch_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
    logic             overflow_err_q, overflow_err_d;
    logic             underflow_err_q, underflow_err_d;

    logic             empty_s, full_s, res_valid_s, mis_s, push_ok_s;
    logic [PC_W-1:0]  head_pc_s, head_target_s;
    logic             head_taken_s;

    // Head inspection and accept/mispredict decisions for this cycle.
    always_comb begin
        head_pc_s     = entry_pc_q[head_q];
        head_target_s = entry_target_q[head_q];
        head_taken_s  = entry_taken_q[head_q];
        empty_s       = (occ_q == {OCC_W{1'b0}});
        full_s        = (occ_q == OCC_W'(DEPTH));
        res_valid_s   = bus.resolve && !empty_s;
        if (res_valid_s) begin
            mis_s = (head_taken_s != bus.resolve_taken) ||
                    (head_taken_s && bus.resolve_taken && (head_target_s != bus.resolve_target));
        end else begin
            mis_s = 1'b0;
        end
        // A mispredict flushes the wrong path, including a same-cycle push.
        push_ok_s = bus.push && !mis_s && (!full_s || res_valid_s);
    end

    // Next-state for pointers, occupancy, result registers, counters and flags.
    always_comb begin
        head_d             = head_q;
        tail_d             = tail_q;
        occ_d              = occ_q;
        update_d           = res_valid_s;
        mispredict_d       = mis_s;
        update_address_d   = update_address_q;
        branch_taken_d     = branch_taken_q;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        overflow_err_d     = overflow_err_q || (bus.push && full_s && !res_valid_s);
        underflow_err_d    = underflow_err_q || (bus.resolve && empty_s);

        if (mis_s) begin
            head_d = tail_q;
            occ_d  = {OCC_W{1'b0}};
        end else begin
            if (res_valid_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            if (push_ok_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({push_ok_s, res_valid_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        if (res_valid_s) begin
            update_address_d = head_pc_s[7:0];
            branch_taken_d   = bus.resolve_taken;
            redirect_pc_d    = bus.resolve_taken ? bus.resolve_target : (head_pc_s + PC_W'(4));
            if (branch_count_q != {CNT_W{1'b1}}) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end else begin
                branch_count_d = branch_count_q;
            end
            if (mis_s && (mispredict_count_q != {CNT_W{1'b1}})) begin
                mispredict_count_d = mispredict_count_q + CNT_W'(1);
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            update_address_d = update_address_q;
        end
    end

    // Entry write at tail for accepted pushes.
    always_comb begin
        entry_pc_d     = entry_pc_q;
        entry_target_d = entry_target_q;
        entry_taken_d  = entry_taken_q;
        if (push_ok_s) begin
            entry_pc_d[tail_q]     = bus.push_pc;
            entry_target_d[tail_q] = bus.push_pred_target;
            entry_taken_d[tail_q]  = bus.push_pred_taken;
        end else begin
            entry_taken_d = entry_taken_q;
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        entry_pc_q     <= entry_pc_d;
        entry_target_q <= entry_target_d;
        entry_taken_q  <= entry_taken_d;
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q             <= {PTR_W{1'b0}};
            tail_q             <= {PTR_W{1'b0}};
            occ_q              <= {OCC_W{1'b0}};
            update_q           <= 1'b0;
            update_address_q   <= 8'h00;
            branch_taken_q     <= 1'b0;
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= {PC_W{1'b0}};
            branch_count_q     <= {CNT_W{1'b0}};
            mispredict_count_q <= {CNT_W{1'b0}};
            overflow_err_q     <= 1'b0;
            underflow_err_q    <= 1'b0;
        end else begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            occ_q              <= occ_d;
            update_q           <= update_d;
            update_address_q   <= update_address_d;
            branch_taken_q     <= branch_taken_d;
            mispredict_q       <= mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            overflow_err_q     <= overflow_err_d;
            underflow_err_q    <= underflow_err_d;
        end
    end

    assign bus.full             = full_s;
    assign bus.empty            = empty_s;
    assign bus.occupancy        = occ_q;
    assign bus.update           = update_q;
    assign bus.update_address   = update_address_q;
    assign bus.branch_taken     = branch_taken_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
    assign bus.overflow_err     = overflow_err_q;
    assign bus.underflow_err    = underflow_err_q;
endmodule
